// File: rtl/section_signal_controller_if.sv
// Signal bundle between the arbiter side and the section signal controller.
// The arbiter/bench drives grant and sensors; the controller drives aspects and status.
interface section_signal_controller_if;
  logic [2:0] grant;
  logic [3:0] entry_sensor;
  logic       exit_sensor;
  logic [3:0] signal_green;
  logic       section_occupied;
  logic       train_done;
  logic [2:0] active_train;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output grant, entry_sensor, exit_sensor,
    input  signal_green, section_occupied, train_done, active_train, fault, fault_code
  );

  modport slave (
    input  grant, entry_sensor, exit_sensor,
    output signal_green, section_occupied, train_done, active_train, fault, fault_code
  );
endinterface

// File: rtl/section_signal_controller.sv
// Drives the four approach signals of a shared track section from the arbiter's grant,
// tracks the granted train through the section and latches into all-red on any inconsistency.
module section_signal_controller #(
  parameter int APPROACH_TIMEOUT = 32,
  parameter int OCCUPY_TIMEOUT   = 64,
  parameter int CLEAR_HOLD       = 4
) (
  input logic clk,
  input logic reset,
  section_signal_controller_if.slave bus
);

  localparam int MAX_AO = (APPROACH_TIMEOUT > OCCUPY_TIMEOUT) ? APPROACH_TIMEOUT : OCCUPY_TIMEOUT;
  localparam int MAX_T  = (MAX_AO > CLEAR_HOLD) ? MAX_AO : CLEAR_HOLD;
  localparam int TW     = $clog2(MAX_T + 1);

  // Timer holds (cycles spent in state - 1) at each edge, so a state ends on its LAST value.
  localparam logic [TW-1:0] APPROACH_LAST = TW'(APPROACH_TIMEOUT - 1);
  localparam logic [TW-1:0] OCCUPY_LAST   = TW'(OCCUPY_TIMEOUT - 1);
  localparam logic [TW-1:0] CLEAR_LAST    = TW'(CLEAR_HOLD - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PROCEED  = 3'd1;
  localparam logic [2:0] S_OCCUPIED = 3'd2;
  localparam logic [2:0] S_CLEARING = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  localparam logic [1:0] CODE_TIMEOUT    = 2'd1;
  localparam logic [1:0] CODE_WRONG_ENTRY = 2'd2;
  localparam logic [1:0] CODE_SPURIOUS   = 2'd3;

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [TW-1:0] timer;
  logic [3:0]    entry_q;
  logic          exit_q;
  logic [3:0]    entry_rise;
  logic          exit_rise;
  logic [2:0]    next_train;
  logic [3:0]    own_mask;
  logic [1:0]    new_code;
  logic          grant_valid;

  always_comb begin
    entry_rise  = bus.entry_sensor & ~entry_q;
    exit_rise   = bus.exit_sensor & ~exit_q;
    grant_valid = (bus.grant != 3'd0) && (bus.grant <= 3'd4);
    next_train  = (state == S_IDLE) ? bus.grant : bus.active_train;
    own_mask    = 4'b0001 << (next_train - 3'd1);
    next_state  = state;
    new_code    = 2'd0;

    case (state)
      S_IDLE: begin
        if (grant_valid) next_state = S_PROCEED;
      end
      S_PROCEED: begin
        // A foreign entry outranks the granted one: two trains may be moving.
        if ((entry_rise & ~own_mask) != 4'b0) begin
          next_state = S_FAULT;
          new_code   = CODE_WRONG_ENTRY;
        end else if ((entry_rise & own_mask) != 4'b0) begin
          next_state = S_OCCUPIED;
        end else if (exit_rise) begin
          next_state = S_FAULT;
          new_code   = CODE_SPURIOUS;
        end else if ((bus.grant != bus.active_train) || (timer == APPROACH_LAST)) begin
          next_state = S_IDLE;
        end
      end
      S_OCCUPIED: begin
        if (entry_rise != 4'b0) begin
          next_state = S_FAULT;
          new_code   = CODE_WRONG_ENTRY;
        end else if (exit_rise) begin
          next_state = S_CLEARING;
        end else if (timer == OCCUPY_LAST) begin
          next_state = S_FAULT;
          new_code   = CODE_TIMEOUT;
        end
      end
      S_CLEARING: begin
        if (entry_rise != 4'b0) begin
          next_state = S_FAULT;
          new_code   = CODE_WRONG_ENTRY;
        end else if (timer == CLEAR_LAST) begin
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so every output is a plain register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      timer                <= '0;
      entry_q              <= 4'b0;
      exit_q               <= 1'b0;
      bus.signal_green     <= 4'b0;
      bus.section_occupied <= 1'b0;
      bus.train_done       <= 1'b0;
      bus.active_train     <= 3'd0;
      bus.fault            <= 1'b0;
      bus.fault_code       <= 2'd0;
    end else begin
      state   <= next_state;
      entry_q <= bus.entry_sensor;
      exit_q  <= bus.exit_sensor;

      if (next_state != state)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;

      bus.signal_green     <= (next_state == S_PROCEED) ? own_mask : 4'b0;
      bus.section_occupied <= (next_state == S_OCCUPIED) || (next_state == S_CLEARING) ||
                              (next_state == S_FAULT);
      bus.train_done       <= (next_state == S_DONE);

      case (next_state)
        S_IDLE, S_DONE: bus.active_train <= 3'd0;
        S_PROCEED:      bus.active_train <= next_train;
        default:        bus.active_train <= bus.active_train;
      endcase

      if ((next_state == S_FAULT) && (state != S_FAULT)) begin
        bus.fault      <= 1'b1;
        bus.fault_code <= new_code;
      end
    end
  end

endmodule

// File: tb/tb_section_signal_controller.sv
// Randomized scoreboard bench for section_signal_controller: a phase/deadline reference
// model queues the expected outputs, and a monitor compares them after every clock edge.
module tb_section_signal_controller;

  localparam int APPROACH_T = 32;
  localparam int OCCUPY_T   = 64;
  localparam int CLEAR_T    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  section_signal_controller_if bus ();

  section_signal_controller #(
    .APPROACH_TIMEOUT(APPROACH_T),
    .OCCUPY_TIMEOUT  (OCCUPY_T),
    .CLEAR_HOLD      (CLEAR_T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef enum int {P_IDLE, P_PROCEED, P_OCCUPIED, P_CLEARING, P_DONE, P_FAULT} phase_t;

  typedef struct packed {
    logic [3:0] green;
    logic       occ;
    logic       done;
    logic [2:0] active;
    logic       fault;
    logic [1:0] code;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  phase_t     m_phase;
  logic [2:0] m_train;
  logic [1:0] m_code;
  int         m_now;
  int         m_deadline;
  logic [3:0] m_prev_entry;
  logic       m_prev_exit;

  function automatic logic [3:0] ownMask(input logic [2:0] g);
    logic [3:0] m;
    m = 4'b0;
    if (g >= 3'd1 && g <= 3'd4) m[g - 3'd1] = 1'b1;
    return m;
  endfunction

  task automatic modelReset();
    m_phase      = P_IDLE;
    m_train      = 3'd0;
    m_code       = 2'd0;
    m_deadline   = 0;
    m_prev_entry = 4'b0;
    m_prev_exit  = 1'b0;
  endtask

  // Each phase has a deadline (absolute step number) instead of a running counter.
  task automatic modelStep(input logic [2:0] g, input logic [3:0] e, input logic x);
    logic [3:0] rise_e;
    logic [3:0] own;
    logic       rise_x;
    phase_t     nxt;
    obs_t       o;
    m_now++;
    rise_e       = e & ~m_prev_entry;
    rise_x       = x & ~m_prev_exit;
    m_prev_entry = e;
    m_prev_exit  = x;
    own          = ownMask(m_train);
    nxt          = m_phase;
    case (m_phase)
      P_IDLE: if (g >= 3'd1 && g <= 3'd4) begin nxt = P_PROCEED; m_train = g; end
      P_PROCEED: begin
        if ((rise_e & ~own) != 4'b0)      begin nxt = P_FAULT; m_code = 2'd2; end
        else if ((rise_e & own) != 4'b0)  nxt = P_OCCUPIED;
        else if (rise_x)                  begin nxt = P_FAULT; m_code = 2'd3; end
        else if (g != m_train || m_now >= m_deadline) nxt = P_IDLE;
      end
      P_OCCUPIED: begin
        if (rise_e != 4'b0)             begin nxt = P_FAULT; m_code = 2'd2; end
        else if (rise_x)                nxt = P_CLEARING;
        else if (m_now >= m_deadline)   begin nxt = P_FAULT; m_code = 2'd1; end
      end
      P_CLEARING: begin
        if (rise_e != 4'b0)             begin nxt = P_FAULT; m_code = 2'd2; end
        else if (m_now >= m_deadline)   nxt = P_DONE;
      end
      P_DONE:  nxt = P_IDLE;
      default: nxt = m_phase;
    endcase
    if (nxt != m_phase) begin
      m_phase = nxt;
      case (nxt)
        P_PROCEED:  m_deadline = m_now + APPROACH_T;
        P_OCCUPIED: m_deadline = m_now + OCCUPY_T;
        P_CLEARING: m_deadline = m_now + CLEAR_T;
        default:    m_deadline = 0;
      endcase
    end
    o.green  = (m_phase == P_PROCEED) ? ownMask(m_train) : 4'b0;
    o.occ    = (m_phase == P_OCCUPIED) || (m_phase == P_CLEARING) || (m_phase == P_FAULT);
    o.done   = (m_phase == P_DONE);
    o.active = (m_phase == P_IDLE || m_phase == P_DONE) ? 3'd0 : m_train;
    o.fault  = (m_phase == P_FAULT);
    o.code   = (m_phase == P_FAULT) ? m_code : 2'd0;
    exp_q.push_back(o);
  endtask

  task automatic checkOutput(input obs_t exp, input string tag);
    obs_t act;
    act = {bus.signal_green, bus.section_occupied, bus.train_done,
           bus.active_train, bus.fault, bus.fault_code};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got green=%b occ=%b done=%b active=%0d fault=%b code=%0d, want green=%b occ=%b done=%b active=%0d fault=%b code=%0d",
               tag, $time, act.green, act.occ, act.done, act.active, act.fault, act.code,
               exp.green, exp.occ, exp.done, exp.active, exp.fault, exp.code);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() != 0) checkOutput(exp_q.pop_front(), "cycle");
  end

  task automatic applyStimulus(input logic [2:0] g, input logic [3:0] e, input logic x);
    @(negedge clk);
    bus.grant        = g;
    bus.entry_sensor = e;
    bus.exit_sensor  = x;
    modelStep(g, e, x);
  endtask

  // Reset lands mid-cycle so the zeroed outputs prove the reset is asynchronous.
  task automatic applyReset();
    @(negedge clk);
    #2;
    reset            = 1'b1;
    bus.grant        = 3'd0;
    bus.entry_sensor = 4'b0;
    bus.exit_sensor  = 1'b0;
    #1 checkOutput('0, "async_reset");
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic nominalRun(input logic [2:0] g, input bit drop_grant, input bit mid_reset);
    int         hold;
    int         held;
    logic [2:0] g2;
    bit         both;
    repeat ($urandom_range(1, 10)) applyStimulus(g, 4'b0, 1'b0);
    both = ($urandom_range(0, 3) == 0);
    applyStimulus(g, ownMask(g), both);
    hold = $urandom_range(1, 40);
    held = $urandom_range(0, hold);
    for (int i = 0; i < hold; i++) begin
      g2 = drop_grant ? 3'($urandom_range(0, 7)) : g;
      applyStimulus(g2, (i < held) ? ownMask(g) : 4'b0, 1'b0);
    end
    applyStimulus(3'd0, 4'b0, 1'b1);
    if (mid_reset) begin
      applyStimulus(3'd0, 4'b0, 1'b1);
      applyReset();
      applyStimulus(3'd1, 4'b0, 1'b0);
      applyStimulus(3'd1, 4'b0, 1'b0);
      applyStimulus(3'd0, 4'b0, 1'b0);
    end else begin
      repeat (CLEAR_T + 3) applyStimulus(3'd0, 4'b0, 1'($urandom_range(0, 1)));
      applyStimulus(3'd0, 4'b0, 1'b0);
    end
  endtask

  task automatic approachTimeoutRun(input logic [2:0] g);
    repeat (APPROACH_T + 3) applyStimulus(g, 4'b0, 1'b0);
    repeat (2) applyStimulus(3'd0, 4'b0, 1'b0);
  endtask

  task automatic withdrawRun(input logic [2:0] g, input int k, input logic [2:0] other);
    repeat (k) applyStimulus(g, 4'b0, 1'b0);
    applyStimulus(other, 4'b0, 1'b0);
    repeat (2) applyStimulus(3'd0, 4'b0, 1'b0);
  endtask

  task automatic wrongApproachRun(input logic [2:0] g, input int b, input bit with_own);
    logic [3:0] e;
    repeat ($urandom_range(1, 5)) applyStimulus(g, 4'b0, 1'b0);
    e = ownMask(3'(b + 1)) | (with_own ? ownMask(g) : 4'b0);
    applyStimulus(g, e, 1'b0);
    repeat (6) applyStimulus(3'($urandom_range(0, 7)), 4'b0, 1'($urandom_range(0, 1)));
    applyReset();
  endtask

  task automatic occupyTimeoutRun(input logic [2:0] g);
    applyStimulus(g, 4'b0, 1'b0);
    applyStimulus(g, ownMask(g), 1'b0);
    repeat (OCCUPY_T + 4) applyStimulus(3'($urandom_range(0, 7)), ownMask(g), 1'b0);
    applyReset();
  endtask

  task automatic spuriousExitRun(input logic [2:0] g);
    repeat ($urandom_range(1, 5)) applyStimulus(g, 4'b0, 1'b0);
    repeat (4) applyStimulus(g, 4'b0, 1'b1);
    applyReset();
  endtask

  task automatic clearingEntryRun(input logic [2:0] g);
    applyStimulus(g, 4'b0, 1'b0);
    applyStimulus(g, ownMask(g), 1'b0);
    repeat (2) applyStimulus(3'd0, 4'b0, 1'b0);
    applyStimulus(3'd0, 4'b0, 1'b1);
    repeat ($urandom_range(0, CLEAR_T - 1)) applyStimulus(3'd0, 4'b0, 1'b1);
    applyStimulus(3'd0, ownMask(3'($urandom_range(1, 4))), 1'b1);
    repeat (3) applyStimulus(3'd0, 4'b0, 1'b0);
    applyReset();
  endtask

  task automatic heldEntryRun(input logic [2:0] g);
    applyStimulus(g, 4'b0, 1'b0);
    applyStimulus(g, ownMask(g), 1'b0);
    repeat (3) applyStimulus(3'd0, ownMask(g), 1'b0);
    applyStimulus(3'd0, ownMask(g), 1'b1);
    repeat (CLEAR_T + 2) applyStimulus(3'd0, ownMask(g), 1'b0);
    repeat (APPROACH_T + 2) applyStimulus(g, ownMask(g), 1'b0);
    repeat (2) applyStimulus(3'd0, 4'b0, 1'b0);
  endtask

  task automatic invalidGrantRun();
    repeat (5) applyStimulus(3'($urandom_range(5, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    applyStimulus(3'd0, 4'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] g;
    logic [2:0] other;
    reset            = 1'b0;
    bus.grant        = 3'd0;
    bus.entry_sensor = 4'b0;
    bus.exit_sensor  = 1'b0;
    m_now            = 0;
    modelReset();
    #1 reset = 1'b1;
    #1 checkOutput('0, "reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    nominalRun(3'd2, 1'b0, 1'b0);
    approachTimeoutRun(3'd1);
    withdrawRun(3'd1, 5, 3'd0);
    wrongApproachRun(3'd3, 0, 1'b0);
    occupyTimeoutRun(3'd4);
    spuriousExitRun(3'd2);
    nominalRun(3'd3, 1'b1, 1'b0);
    heldEntryRun(3'd1);
    nominalRun(3'd4, 1'b0, 1'b1);
    clearingEntryRun(3'd2);
    invalidGrantRun();

    for (int it = 0; it < 30; it++) begin
      g = 3'($urandom_range(1, 4));
      case ($urandom_range(0, 8))
        0: nominalRun(g, 1'($urandom_range(0, 1)), 1'b0);
        1: approachTimeoutRun(g);
        2: begin
          other = 3'($urandom_range(0, 7));
          if (other == g) other = 3'd0;
          withdrawRun(g, $urandom_range(2, 20), other);
        end
        3: wrongApproachRun(g, (int'(g) - 1 + $urandom_range(1, 3)) % 4, 1'($urandom_range(0, 1)));
        4: occupyTimeoutRun(g);
        5: spuriousExitRun(g);
        6: clearingEntryRun(g);
        7: heldEntryRun(g);
        default: nominalRun(g, 1'b0, 1'b1);
      endcase
      if ($urandom_range(0, 3) == 0) invalidGrantRun();
    end

    repeat (2) applyStimulus(3'd0, 4'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
